uart_tx_feeder: RTL

Byte buffer and launch sequencer directly upstream of the UART transmitter in `uart_top`. Software or bus-side logic pushes bytes into an internal FIFO. The block pops one byte at a time, presents it on `tx_data_in`, and pulses `tx_start` for exactly one cycle. It then waits for the transmitter's end-of-frame pulse before launching the next byte. This lets back-to-back bytes be queued without the host having to track the transmitter's timing.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_byte_fifo.sv | 53 +++++
 rtl/uart_tx_feeder.sv | 66 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the tx feeder state encoding.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with registered occupancy count and overflow pulse.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [ADDR_W-1:0]            wr_ptr, rd_ptr;
  logic                         push, pop;

  // full is never bypassed by a same-cycle pop
  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and launches them one at a time into the UART transmitter.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data_in,
  input  logic              tx_done
);
  feeder_state_t     state, state_nxt;
  logic              pop;
  logic [DATA_W-1:0] head;

  uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (tx_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // tx_data_in only moves on the IDLE->START pop, so it is stable through the frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    tx_data_in <= '0;
    else if (pop) tx_data_in <= head;
  end

  assign tx_start = (state == ST_START);
  assign busy     = (state != ST_IDLE);
endmodule
